aes_inv_round_engine: RTL and testbench

Iterative AES decipher datapath with a configurable number of parallel inverse S-box lanes and AES-128/192/256 support. It sits beside the key memory inside the AES core. It requests round keys by index and turns one 128-bit ciphertext block into plaintext per `next` command. Each decryption ends with a one-cycle `done` strobe alongside the level `ready`.

---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_inv_sbox.sv | 29 ++
 rtl/aes_inv_round_engine.sv | 132 +++++++++++++
 tb/tb_aes_inv_round_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES decipher definitions: key-length encodings, round counts and the
// byte/column transforms used by the inverse round engine.
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_256 = 2'b01;
  localparam logic [1:0] KEYLEN_192 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_SBOX = 3'd2,
    ST_MAIN = 3'd3
  } state_t;

  // 2'b11 is not a legal key length and falls back to AES-128.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_256: return NR_256;
      KEYLEN_192: return NR_192;
      default:    return NR_128;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      b[i]  = w[31-8*i -: 8];
      x2[i] = gm2(b[i]);
      x4[i] = gm2(x2[i]);
      x8[i] = gm2(x4[i]);
      m9[i] = x8[i] ^ b[i];
      mb[i] = x8[i] ^ x2[i] ^ b[i];
      md[i] = x8[i] ^ x4[i] ^ b[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]), inv_mixw(s[63:32]), inv_mixw(s[31:0])};
  endfunction

  // Byte (row, col) sits at position 4*col + row; row r rotates right by r columns.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four-byte inverse S-box lane: one 32-bit state word per lookup.
module aes_inv_sbox (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign word_out = {INV_SBOX[word_in[31:24]], INV_SBOX[word_in[23:16]],
                     INV_SBOX[word_in[15:8]],  INV_SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128/192/256 decipher round engine with NUM_SBOX inverse S-box lanes.
//   state   | meaning
//   IDLE    | result held, ready high, waiting for next
//   INIT    | load InvShiftRows(block ^ key[Nr])
//   SBOX    | InvSubBytes on NUM_SBOX words per cycle
//   MAIN    | AddRoundKey (+ InvMixColumns/InvShiftRows unless last round)
module aes_inv_round_engine
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         done
);

  localparam int S = 4 / NUM_SBOX;
  localparam logic [1:0] SWORD_LAST = 2'(S - 1);

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("aes_inv_round_engine: NUM_SBOX must be 1, 2 or 4");
  end

  state_t         fsm_q, fsm_d;
  logic [3:0]     round_ctr, round_d;
  logic [1:0]     keylen_reg, keylen_d;
  logic [1:0]     sword_ctr, sword_d;
  logic [127:0]   blk_q, blk_d, blk_sub;
  logic           ready_q, ready_d, done_q, done_d;

  logic [1:0]     widx     [NUM_SBOX];
  logic [31:0]    sbox_in  [NUM_SBOX];
  logic [31:0]    sbox_out [NUM_SBOX];

  // Word index wraps mod 4 so stale sword_ctr values outside SBOX stay in range.
  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
    assign widx[k]    = 2'(int'(sword_ctr) * NUM_SBOX + k);
    assign sbox_in[k] = blk_q[127 - 32*int'(widx[k]) -: 32];
    aes_inv_sbox u_sbox (
      .word_in  (sbox_in[k]),
      .word_out (sbox_out[k])
    );
  end

  always_comb begin
    blk_sub = blk_q;
    for (int k = 0; k < NUM_SBOX; k++) begin
      blk_sub[127 - 32*int'(widx[k]) -: 32] = sbox_out[k];
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    round_d  = round_ctr;
    keylen_d = keylen_reg;
    sword_d  = sword_ctr;
    blk_d    = blk_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (next) begin
          round_d  = nr_of(keylen);
          keylen_d = keylen;
          ready_d  = 1'b0;
          fsm_d    = ST_INIT;
        end
      end
      ST_INIT: begin
        // Re-derive the round count from the captured length; keylen may move now.
        blk_d   = inv_shiftrows(addroundkey(block, round_key));
        round_d = nr_of(keylen_reg);
        sword_d = 2'd0;
        fsm_d   = ST_SBOX;
      end
      ST_SBOX: begin
        blk_d   = blk_sub;
        sword_d = sword_ctr + 2'd1;
        if (sword_ctr == SWORD_LAST) begin
          round_d = round_ctr - 4'd1;
          fsm_d   = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (round_ctr != 4'd0) begin
          blk_d   = inv_shiftrows(inv_mixcolumns(addroundkey(blk_q, round_key)));
          sword_d = 2'd0;
          fsm_d   = ST_SBOX;
        end else begin
          blk_d   = addroundkey(blk_q, round_key);
          ready_d = 1'b1;
          done_d  = 1'b1;
          fsm_d   = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= ST_IDLE;
      round_ctr  <= 4'd0;
      keylen_reg <= 2'd0;
      sword_ctr  <= 2'd0;
      blk_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      round_ctr  <= round_d;
      keylen_reg <= keylen_d;
      sword_ctr  <= sword_d;
      blk_q      <= blk_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign round     = round_ctr;
  assign new_block = blk_q;
  assign ready     = ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: three instances (1/2/4 lanes) driven in lockstep
// against an arithmetic FIPS-197 inverse-cipher model and key schedule.
module tb_aes_inv_round_engine;

  localparam int M_NORM    = 0;
  localparam int M_PERTURB = 1;
  localparam int M_BUSY    = 2;
  localparam int M_B2B     = 3;
  localparam int M_RESET   = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   nxt;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [3:0]   rnd  [3];
  logic [127:0] rkey [3];
  logic [127:0] nb   [3];
  logic [2:0]   rdy, dn;

  logic [127:0] keys [16];
  logic [7:0]   sb   [256];
  logic [7:0]   isb  [256];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rkey[0] = keys[rnd[0]];
  assign rkey[1] = keys[rnd[1]];
  assign rkey[2] = keys[rnd[2]];

  aes_inv_round_engine #(.NUM_SBOX(1)) u_n1 (
    .clk(clk), .reset_n(reset_n), .next(nxt[0]), .keylen(keylen), .round(rnd[0]),
    .round_key(rkey[0]), .block(block), .new_block(nb[0]), .ready(rdy[0]), .done(dn[0]));
  aes_inv_round_engine #(.NUM_SBOX(2)) u_n2 (
    .clk(clk), .reset_n(reset_n), .next(nxt[1]), .keylen(keylen), .round(rnd[1]),
    .round_key(rkey[1]), .block(block), .new_block(nb[1]), .ready(rdy[1]), .done(dn[1]));
  aes_inv_round_engine #(.NUM_SBOX(4)) u_n4 (
    .clk(clk), .reset_n(reset_n), .next(nxt[2]), .keylen(keylen), .round(rnd[2]),
    .round_key(rkey[2]), .block(block), .new_block(nb[2]), .ready(rdy[2]), .done(dn[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 254; i++) p = gmul(p, a);
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic int kl_nr(input logic [1:0] kl);
    return (kl == 2'b01) ? 14 : (kl == 2'b10) ? 12 : 10;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic set_key(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, nk;
    nr = kl_nr(kl);
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      keys[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Textbook inverse cipher over a byte array, using the current key table.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] k, out;
    k = keys[nr];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = s[row+4*((c-row+4)%4)];
      k = keys[r];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ k[127-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          s[4*c]   = gmul(a[0],8'h0e) ^ gmul(a[1],8'h0b) ^ gmul(a[2],8'h0d) ^ gmul(a[3],8'h09);
          s[4*c+1] = gmul(a[0],8'h09) ^ gmul(a[1],8'h0e) ^ gmul(a[2],8'h0b) ^ gmul(a[3],8'h0d);
          s[4*c+2] = gmul(a[0],8'h0d) ^ gmul(a[1],8'h09) ^ gmul(a[2],8'h0e) ^ gmul(a[3],8'h0b);
          s[4*c+3] = gmul(a[0],8'h0b) ^ gmul(a[1],8'h0d) ^ gmul(a[2],8'h09) ^ gmul(a[3],8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // Latency counts clock edges from the one that samples next up to the one raising ready.
  task automatic run_op(input string tag, input logic [1:0] kl, input logic [127:0] ct,
                        input logic [127:0] pt, input int mode);
    int nr, k, rsum;
    int ph [3];
    int lat [3];
    int lat2 [3];
    int dcnt [3];
    int rose [3];
    int pulse2 [3];
    logic [63:0] seq [3];
    logic [63:0] seq_exp;
    logic [3:0]  last [3];
    bit all_fin;
    nr = kl_nr(kl);
    pulse2[0] = 30; pulse2[1] = 30; pulse2[2] = 20;
    @(negedge clk);
    keylen = kl;
    block  = ct;
    nxt    = 3'b111;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    if (mode != M_B2B) nxt = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; lat[i] = -1; lat2[i] = -1; dcnt[i] = 0; rose[i] = 0;
      seq[i] = 64'(rnd[i]); last[i] = rnd[i];
    end
    chk({tag, "_rdy_fall"}, 128'(rdy), 128'(3'b000));
    while (k < 200) begin
      if (mode == M_PERTURB) begin
        keylen = 2'($urandom);
        if (k >= 1) block = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mode == M_BUSY)
        for (int i = 0; i < 3; i++) nxt[i] = (k + 1 == 5) || (k + 1 == pulse2[i]);
      if (mode == M_RESET && k == 20) begin
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_rst_rdy"}, 128'(rdy), 128'(3'b111));
        chk({tag, "_rst_done"}, 128'(dn), 128'(3'b000));
        chk({tag, "_rst_round"}, 128'({rnd[0], rnd[1], rnd[2]}), 128'h0);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_rst_nb%0d", tag, i), nb[i], 128'h0);
        rsum = dcnt[0] + dcnt[1] + dcnt[2];
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (dn != 3'b000) rsum++;
        end
        chk({tag, "_rst_no_done"}, 128'(rsum), 128'(0));
        reset_n = 1'b1;
        return;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) dcnt[i]++;
        if (rnd[i] != last[i]) begin
          seq[i]  = {seq[i][59:0], rnd[i]};
          last[i] = rnd[i];
        end
        case (ph[i])
          0: if (rdy[i]) begin
               lat[i] = k + 1;
               chk($sformatf("%s_done_at_rdy%0d", tag, i), 128'(dn[i]), 128'(1));
               chk($sformatf("%s_pt%0d", tag, i), nb[i], pt);
               ph[i] = 1;
             end
          1: if (mode == M_B2B) begin
               chk($sformatf("%s_b2b_gap%0d", tag, i), 128'(rdy[i]), 128'(0));
               nxt[i]  = 1'b0;
               rose[i] = k;
               ph[i]   = 2;
             end else begin
               ph[i] = 4;
             end
          2: if (rdy[i]) begin
               lat2[i] = k - rose[i] + 1;
               chk($sformatf("%s_b2b_pt%0d", tag, i), nb[i], pt);
               ph[i] = 4;
             end
          default: ;
        endcase
      end
      all_fin = (ph[0] == 4) && (ph[1] == 4) && (ph[2] == 4);
      if (all_fin && (mode != M_BUSY || k >= 45)) break;
    end
    nxt = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_lat%0d", tag, i), 128'(lat[i]), 128'(2 + nr * (4 / (1 << i) + 1)));
      chk($sformatf("%s_ndone%0d", tag, i), 128'(dcnt[i]), 128'((mode == M_B2B) ? 2 : 1));
      if (mode == M_B2B)
        chk($sformatf("%s_b2b_lat%0d", tag, i), 128'(lat2[i]), 128'(2 + nr * (4 / (1 << i) + 1)));
      if (mode == M_NORM) begin
        seq_exp = 64'h0;
        for (int v = nr; v >= 0; v--) seq_exp = {seq_exp[59:0], 4'(v)};
        chk($sformatf("%s_round_seq%0d", tag, i), 128'(seq[i]), 128'(seq_exp));
      end
    end
    if (mode == M_BUSY) chk({tag, "_still_idle"}, 128'(rdy), 128'(3'b111));
  endtask

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    int changed;
    logic [255:0] rk;
    logic [127:0] ct;
    logic [1:0]   kl;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, b;
      v = 8'(x);
      b = ginv(v);
      sb[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      b = rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05;
      isb[x] = ginv(b);
    end
    for (int r = 0; r < 16; r++) keys[r] = 128'h0;
    reset_n = 1'b0;
    nxt     = 3'b000;
    keylen  = 2'b00;
    block   = 128'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(rdy), 128'(3'b111));
    chk("rst_done", 128'(dn), 128'(3'b000));
    chk("rst_round", 128'({rnd[0], rnd[1], rnd[2]}), 128'h0);
    chk("rst_nb", nb[0] | nb[1] | nb[2], 128'h0);
    changed = 0;
    repeat (20) begin
      block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (rdy !== 3'b111 || dn !== 3'b000 || (nb[0] | nb[1] | nb[2]) !== 128'h0 ||
          {rnd[0], rnd[1], rnd[2]} !== 12'h0)
        changed++;
    end
    chk("idle_stable", 128'(changed), 128'(0));

    set_key(KEY128, 2'b00);
    run_op("aes128", 2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, M_NORM);
    set_key(KEY192, 2'b10);
    run_op("aes192", 2'b10, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, M_NORM);
    set_key(KEY256, 2'b01);
    run_op("aes256_perturb", 2'b01, 128'h8ea2b7ca516745bfeafc49904b496089, PT, M_PERTURB);

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      kl = 2'($urandom_range(0, 3));
      set_key(rk, kl);
      run_op($sformatf("rand%0d_kl%0d", n, kl), kl, ct, ref_decrypt(ct, kl_nr(kl)), M_NORM);
    end

    set_key(KEY128, 2'b00);
    run_op("busy", 2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, M_BUSY);
    ct = {$urandom, $urandom, $urandom, $urandom};
    run_op("b2b", 2'b00, ct, ref_decrypt(ct, 10), M_B2B);

    set_key(KEY256, 2'b01);
    run_op("reset", 2'b01, 128'h8ea2b7ca516745bfeafc49904b496089, PT, M_RESET);
    run_op("restart256", 2'b01, 128'h8ea2b7ca516745bfeafc49904b496089, PT, M_NORM);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
